// File: rtl/line_buffer.sv
// line_buffer: buffers K-1 image rows and emits one vertical pixel column per
// accepted pixel once enough rows are stored; frames are re-primed each time.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_data/in_valid/in_ready    - raster pixel stream in
//   out_data/out_valid/out_ready - column out, top row in the low slice
module line_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int KERNEL_HEIGHT = 3,
  parameter int OUTPUT_WIDTH  = DATA_WIDTH * KERNEL_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int NL = KERNEL_HEIGHT - 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_PRIME = RW'(KERNEL_HEIGHT - 2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          xfer;
  logic          col_last;

  logic [DATA_WIDTH-1:0] line_mem [NL][IMG_WIDTH];

  // While filling, everything is absorbed; while streaming the block is
  // a pure passthrough so input and output transfers coincide.
  assign in_ready  = (state == S_FILL) ? 1'b1 : out_ready;
  assign out_valid = (state == S_STREAM) && in_valid;
  assign xfer      = in_valid && in_ready;
  assign col_last  = (col_cnt == COL_LAST);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NL; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = line_mem[i][col_cnt];
    end
    out_data[NL*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FILL;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (xfer) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        unique case (1'b1)
          (state == S_FILL) && (row_cnt == ROW_PRIME):
            state <= S_STREAM;
          (state == S_STREAM) && (row_cnt == ROW_LAST):
            state <= S_FILL;
          default:
            state <= state;
        endcase
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Vertical shift at the current column: oldest row drops out of line 0,
  // the new pixel lands in the newest line. Memories carry no reset; the
  // fill phase rewrites every location before it can be emitted.
  always_ff @(posedge clk) begin
    if (!rst && xfer) begin
      for (int i = 0; i < NL - 1; i++) begin
        line_mem[i][col_cnt] <= line_mem[i+1][col_cnt];
      end
      line_mem[NL-1][col_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: randomized and directed checks of line_buffer against a
// frame-image reference model.
module tb_line_buffer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int K  = 3;
  localparam int OW = DW * K;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  line_buffer #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .KERNEL_HEIGHT(K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference: pixel index within the current frame plus the frame image
  int            p = 0;
  logic [DW-1:0] frame [H][W];
  int            ncols = 0;

  logic          obs_valid;
  logic          obs_ready;
  logic [OW-1:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic r, input logic rs);
    int row;
    int col;
    logic er;
    logic ev;
    logic [OW-1:0] ed;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    #1;
    row = p / W;
    col = p % W;
    er  = (row < K - 1) ? 1'b1 : r;
    ev  = (row >= K - 1) && v;
    ed  = '0;
    ed[(K-1)*DW +: DW] = d;
    if (row >= K - 1) begin
      for (int j = 0; j < K - 1; j++) begin
        ed[j*DW +: DW] = frame[row-(K-1)+j][col];
      end
    end
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) chk("out_data", 32'(out_data), 32'(ed));
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_data  = out_data;
    @(posedge clk);
    if (rs) begin
      p = 0;
    end else if (v && er) begin
      frame[row][col] = d;
      if (ev) ncols++;
      p = (p + 1) % (W * H);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r * 16 + c);
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    p = 0;

    // post-reset state, then fill and stream one frame
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("reset_ready", 32'(obs_ready), 32'd1);
    chk("reset_valid", 32'(obs_valid), 32'd0);
    ncols = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, pix(r, c), 1'b1, 1'b0);
        if (r == 2 && c == 0) chk("first_col", 32'(obs_data), 32'h201000);
        if (r == 2 && c == 1) chk("col_21", 32'(obs_data), 32'h211101);
        if (r == 3 && c == 3) chk("last_col", 32'(obs_data), 32'h332313);
      end
    end
    chk("cols_frame1", 32'(ncols), 32'd8);

    // second frame: re-prime, then backpressure at 0x22, then gaps
    ncols = 0;
    for (int q = 0; q < 10; q++) begin
      step(1'b1, pix(q / W, q % W), 1'b1, 1'b0);
      if (q == 8) chk("f2_first_col", 32'(obs_data), 32'h201000);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h22, 1'b0, 1'b0);
      chk("bp_data", 32'(obs_data), 32'h221202);
      chk("bp_ready", 32'(obs_ready), 32'd0);
    end
    step(1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b1, 8'h23, 1'b1, 1'b0);
    chk("bp_next", 32'(obs_data), 32'h231303);
    for (int q = 12; q < 16; q++) begin
      step(1'b0, 8'hee, 1'b1, 1'b0);
      chk("gap_valid", 32'(obs_valid), 32'd0);
      step(1'b1, pix(q / W, q % W), 1'b1, 1'b0);
    end
    chk("cols_frame2", 32'(ncols), 32'd8);

    // reset mid-fill with a pixel presented
    for (int q = 0; q < 6; q++) step(1'b1, pix(q / W, q % W), 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    for (int q = 0; q < 8; q++) step(1'b1, pix(q / W, q % W), 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b1, 1'b0);
    chk("refill_valid", 32'(obs_valid), 32'd1);
    chk("refill_col", 32'(obs_data), 32'h201000);

    // reset mid-stream while 0x21 is presented
    step(1'b1, 8'h21, 1'b1, 1'b1);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("rst_stream_valid", 32'(obs_valid), 32'd0);
    chk("rst_stream_ready", 32'(obs_ready), 32'd1);

    // randomized traffic against the frame model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) != 0), DW'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
Name: line_buffer

Overview:
Upstream neighbour of the horizontal kernel shift register in the HOG front end. Accepts a raster-order pixel stream and buffers the previous KERNEL_HEIGHT-1 image rows in line memories. For every accepted pixel, once enough rows are buffered, it emits one vertical column of KERNEL_HEIGHT pixels at the same image column. The kernel shift register then assembles these columns into a 2D window.

Parameters:
DATA_WIDTH, 8, bits per pixel
IMG_WIDTH, 640, pixels per image row (>=2)
IMG_HEIGHT, 480, rows per frame (>=KERNEL_HEIGHT)
KERNEL_HEIGHT, 3, rows per output column (>=2)
OUTPUT_WIDTH, DATA_WIDTH*KERNEL_HEIGHT, output column width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active high
in_data  in  DATA_WIDTH  raster pixel
in_valid  in  1  in_data valid
in_ready  out  1  block can accept in_data
out_data  out  OUTPUT_WIDTH  pixel column; slice [DATA_WIDTH-1:0] is the oldest (top) row; the MSB slice is the current in_data (bottom row)
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset: clk and rst only (single clock); rst sampled on the rising edge.
  - Reset sets state=S_FILL, col_cnt=0, row_cnt=0.
  - out_valid and in_ready are combinational; their post-reset values follow the rules below.
  - Line memories are not cleared. Stale contents are never emitted.
- Transfer: in_valid && in_ready, called "xfer".
- Handshake:
  - S_FILL: in_ready=1, out_valid=0. Pixels are absorbed with no output.
  - S_STREAM: in_ready=out_ready and out_valid=in_valid. Output is combinational passthrough, 0-cycle latency; an input xfer is exactly an output xfer.
- Storage:
  - KERNEL_HEIGHT-1 line memories line[0..K-2], each IMG_WIDTH x DATA_WIDTH.
  - Read is asynchronous at address col_cnt.
  - out_data = {in_data, line[K-2][col_cnt], ..., line[0][col_cnt]}.
  - out_data is driven in both states; it is only meaningful when out_valid=1.
- Write on each xfer: line[i][col_cnt] <= line[i+1][col_cnt] for i<K-2, and line[K-2][col_cnt] <= in_data (vertical shift at that column). No xfer means no write and no counter change.
- Counters, advancing on xfer only:
  - col_cnt (clog2(IMG_WIDTH) bits) wraps from IMG_WIDTH-1 to 0.
  - On that wrap, row_cnt (clog2(IMG_HEIGHT) bits) increments, wrapping from IMG_HEIGHT-1 to 0.
- State machine:
  - S_FILL -> S_STREAM on xfer with col_cnt==IMG_WIDTH-1 and row_cnt==KERNEL_HEIGHT-2. The first streamed pixel is therefore row K-1, col 0.
  - S_STREAM -> S_FILL on xfer with col_cnt==IMG_WIDTH-1 and row_cnt==IMG_HEIGHT-1 (end of frame).
  - Each frame is therefore re-primed; no columns spanning two frames are ever emitted.
- Simultaneous events:
  - rst has priority over any xfer in the same cycle. That xfer is discarded: no write, no counter change.
  - in_valid=0 while out_ready=1 produces no action.
- Mid-operation reset: partially filled or streamed frame is abandoned. The next accepted pixel is treated as row 0, col 0.
- Emitted columns per frame: exactly IMG_WIDTH*(IMG_HEIGHT-KERNEL_HEIGHT+1).

Test Plan:
(All use IMG_WIDTH=4, IMG_HEIGHT=4, KERNEL_HEIGHT=3, DATA_WIDTH=8; pixel value = row*16+col.)
- Fill then stream:
  - Stimulus: after rst, feed 0x00..0x13 (8 pixels) with out_ready=1, then 0x20.
  - Required: in_ready=1 and out_valid=0 for the first 8 pixels. While 0x20 is presented, out_valid=1 and out_data=0x201000.
  - Continuing: 0x21 -> 0x211101, ..., 0x33 -> 0x332313.
- Backpressure:
  - Stimulus: in S_STREAM presenting 0x22, hold out_ready=0 for 3 cycles.
  - Required: in_ready=0, out_valid=1, out_data stable at 0x221202, no counter advance.
  - Then out_ready=1: one xfer, next column 0x231303.
- Input gaps: in S_STREAM, interleave in_valid=0 cycles. Required: out_valid=0 on those cycles, and the sequence of emitted columns is identical to the gap-free run.
- Frame boundary:
  - Stimulus: after xfer of 0x33, feed a second frame.
  - Required: pixels 0x00..0x13 give out_valid=0 and in_ready=1. Pixel 0x20 gives 0x201000 (no data from frame 1).
  - Total of 8 columns emitted per frame.
- Reset mid-fill: feed 6 pixels, assert rst 1 cycle with in_valid=1. Required: that pixel is not consumed, and 8 further pixels are needed before the first out_valid=1.
- Reset mid-stream: assert rst while streaming 0x21. Required: out_valid=0 the next cycle and the state machine is back in S_FILL.
